// File: rtl/hgate_job_launcher.sv
// ---------------------------------------------------------------------------
// hgate_job_launcher
//
// AXI4-Lite write-only master placed directly in front of the H-Gate slave.
// A job arrives as a stream of (addr, data) register writes. Each beat is
// issued as one AW/W/B transaction, and beats are issued in order. After the
// final beat's write response, the block waits for the slave's completion
// interrupt or for a timeout. It then emits a single done pulse that carries
// the job's error status.
//
// Ports
//   M_AXI_ACLK      clock
//   M_AXI_ARESETN   asynchronous active-low reset (deassert synchronously)
//   job_valid/job_ready/job_addr/job_data/job_last
//                   job beat stream; a beat is taken on valid & ready
//   irq_in          1-cycle completion pulse from the slave
//   done_valid      1-cycle pulse when the job has finished
//   done_err        [0] some BRESP != OKAY in the job, [1] IRQ timeout
//   M_AXI_AW*/W*/B* AXI4-Lite write channels (WSTRB is always all ones)
// ---------------------------------------------------------------------------
module hgate_job_launcher #(
   parameter int C_M_AXI_ADDR_WIDTH = 8,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                                M_AXI_ACLK,
   input  logic                                M_AXI_ARESETN,
   input  logic                                job_valid,
   output logic                                job_ready,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]       job_addr,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]       job_data,
   input  logic                                job_last,
   input  logic                                irq_in,
   output logic                                done_valid,
   output logic [1:0]                          done_err,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR,
   output logic                                M_AXI_AWVALID,
   input  logic                                M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]       M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]     M_AXI_WSTRB,
   output logic                                M_AXI_WVALID,
   input  logic                                M_AXI_WREADY,
   input  logic [1:0]                          M_AXI_BRESP,
   input  logic                                M_AXI_BVALID,
   output logic                                M_AXI_BREADY
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_RESP = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   // The counter must be able to hold TIMEOUT_CYCLES itself. Keep at least
   // one bit so that the disabled (0) case still elaborates.
   localparam int              CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [2:0]                    state_reg;
   logic [C_M_AXI_ADDR_WIDTH-1:0] addr_reg;
   logic [C_M_AXI_DATA_WIDTH-1:0] data_reg;
   logic                          last_reg;
   logic                          awvalid_reg;
   logic                          wvalid_reg;
   logic                          in_job_reg;     // set from first accepted beat until DONE
   logic                          err_bresp_reg;
   logic                          irq_seen_reg;
   logic                          timeout_reg;
   logic [CNT_W-1:0]              cnt_reg;
   logic                          active_reg;     // holds job_ready low while in reset

   // A channel counts as finished when its VALID is already low or when it
   // handshakes in this cycle.
   logic aw_finished;
   logic w_finished;
   assign aw_finished = !awvalid_reg || M_AXI_AWREADY;
   assign w_finished  = !wvalid_reg  || M_AXI_WREADY;

   always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
      if (!M_AXI_ARESETN) begin
         state_reg     <= S_IDLE;
         addr_reg      <= '0;
         data_reg      <= '0;
         last_reg      <= 1'b0;
         awvalid_reg   <= 1'b0;
         wvalid_reg    <= 1'b0;
         in_job_reg    <= 1'b0;
         err_bresp_reg <= 1'b0;
         irq_seen_reg  <= 1'b0;
         timeout_reg   <= 1'b0;
         cnt_reg       <= '0;
         active_reg    <= 1'b0;
      end else begin
         active_reg <= 1'b1;

         // Latch the interrupt outside IDLE so that a pulse arriving while a
         // write response is still outstanding is not lost.
         if (state_reg != S_IDLE && irq_in)
            irq_seen_reg <= 1'b1;

         case (state_reg)
            S_IDLE: begin
               if (job_valid && active_reg) begin
                  addr_reg    <= job_addr;
                  data_reg    <= job_data;
                  last_reg    <= job_last;
                  awvalid_reg <= 1'b1;
                  wvalid_reg  <= 1'b1;
                  state_reg   <= S_ADDR;
                  if (!in_job_reg) begin
                     err_bresp_reg <= 1'b0;
                     irq_seen_reg  <= 1'b0;
                     in_job_reg    <= 1'b1;
                  end
               end
            end
            S_ADDR: begin
               if (M_AXI_AWREADY)
                  awvalid_reg <= 1'b0;
               if (M_AXI_WREADY)
                  wvalid_reg <= 1'b0;
               if (aw_finished && w_finished)
                  state_reg <= S_RESP;
            end
            S_RESP: begin
               if (M_AXI_BVALID) begin
                  if (M_AXI_BRESP != 2'b00)
                     err_bresp_reg <= 1'b1;
                  if (last_reg) begin
                     state_reg   <= S_WAIT;
                     cnt_reg     <= '0;
                     timeout_reg <= 1'b0;
                  end else begin
                     state_reg <= S_IDLE;
                  end
               end
            end
            S_WAIT: begin
               // An interrupt takes priority over a timeout in the same cycle.
               if (irq_seen_reg || irq_in) begin
                  state_reg <= S_DONE;
               end else if (TIMEOUT_CYCLES != 0) begin
                  if (cnt_reg == CNT_LIMIT) begin
                     timeout_reg <= 1'b1;
                     state_reg   <= S_DONE;
                  end else begin
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               in_job_reg <= 1'b0;
               state_reg  <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign job_ready     = active_reg && (state_reg == S_IDLE);
   assign done_valid    = (state_reg == S_DONE);
   assign done_err      = (state_reg == S_DONE) ? {timeout_reg, err_bresp_reg} : 2'b00;
   assign M_AXI_AWADDR  = addr_reg;
   assign M_AXI_AWVALID = awvalid_reg;
   assign M_AXI_WDATA   = data_reg;
   assign M_AXI_WSTRB   = {(C_M_AXI_DATA_WIDTH/8){1'b1}};
   assign M_AXI_WVALID  = wvalid_reg;
   assign M_AXI_BREADY  = (state_reg == S_RESP);

endmodule

// File: tb/tb_hgate_job_launcher.sv
// ---------------------------------------------------------------------------
// tb_hgate_job_launcher
//
// Directed bench for hgate_job_launcher. An AXI slave model runs on the
// falling clock edge and has configurable AWREADY/WREADY/BVALID delays and
// an injectable bad BRESP. It logs every handshake that took place on the
// preceding rising edge. The scenario tasks drive jobs and irq pulses and
// compare against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_hgate_job_launcher;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [7:0]  job_addr  = '0;
   logic [31:0] job_data  = '0;
   logic        job_last  = 1'b0;
   logic        irq_in    = 1'b0;
   logic        done_valid;
   logic [1:0]  done_err;
   logic [7:0]  awaddr;
   logic        awvalid;
   logic        awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready  = 1'b0;
   logic [1:0]  bresp   = 2'b00;
   logic        bvalid  = 1'b0;
   logic        bready;

   hgate_job_launcher #(
      .C_M_AXI_ADDR_WIDTH (8),
      .C_M_AXI_DATA_WIDTH (32),
      .TIMEOUT_CYCLES     (16)
   ) dut (
      .M_AXI_ACLK    (clk),
      .M_AXI_ARESETN (rst_n),
      .job_valid     (job_valid),
      .job_ready     (job_ready),
      .job_addr      (job_addr),
      .job_data      (job_data),
      .job_last      (job_last),
      .irq_in        (irq_in),
      .done_valid    (done_valid),
      .done_err      (done_err),
      .M_AXI_AWADDR  (awaddr),
      .M_AXI_AWVALID (awvalid),
      .M_AXI_AWREADY (awready),
      .M_AXI_WDATA   (wdata),
      .M_AXI_WSTRB   (wstrb),
      .M_AXI_WVALID  (wvalid),
      .M_AXI_WREADY  (wready),
      .M_AXI_BRESP   (bresp),
      .M_AXI_BVALID  (bvalid),
      .M_AXI_BREADY  (bready)
   );

   int checks = 0;
   int passed = 0;

   // slave model configuration
   int aw_lat = 0, w_lat = 0, b_lat = 0, bad_beat = -1;
   // slave model / monitor state
   int cyc = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   int n_aw = 0, n_w = 0, n_b = 0;
   int aw_only = 0, rdy_busy = 0, strb_bad = 0;
   int done_cnt = 0, done_cyc = 0, b_cyc = 0;
   logic [1:0]  done_err_last = 2'b00;
   logic [7:0]  aw_log[$];
   logic [31:0] w_log[$];
   logic        awv_p = 1'b0, wv_p = 1'b0, brdy_p = 1'b0;
   logic [7:0]  awaddr_p = '0;
   logic [31:0] wdata_p  = '0;
   logic [3:0]  wstrb_p  = '0;

   // DUT outputs only change on the rising edge. A value sampled on the
   // previous falling edge is therefore what the slave saw at the edge in
   // between, together with the ready/valid that this block drove.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
         aw_cnt = 0; w_cnt = 0; b_cnt = 0;
         awv_p = 1'b0; wv_p = 1'b0; brdy_p = 1'b0;
      end else begin
         if (awv_p && awready) begin aw_log.push_back(awaddr_p); n_aw++; end
         if (wv_p && wready) begin
            w_log.push_back(wdata_p);
            if (wstrb_p !== 4'hF) strb_bad++;
            n_w++;
         end
         if (bvalid && brdy_p) begin n_b++; b_cyc = cyc; bvalid = 1'b0; b_cnt = 0; end
         if (done_valid) begin done_cnt++; done_cyc = cyc; done_err_last = done_err; end
         if (awvalid && !wvalid) aw_only++;
         if (job_ready && (awvalid || wvalid || bready || done_valid)) rdy_busy++;

         if (awvalid) begin
            if (aw_cnt >= aw_lat) awready = 1'b1;
            else begin awready = 1'b0; aw_cnt++; end
         end else begin
            awready = 1'b0; aw_cnt = 0;
         end
         if (wvalid) begin
            if (w_cnt >= w_lat) wready = 1'b1;
            else begin wready = 1'b0; w_cnt++; end
         end else begin
            wready = 1'b0; w_cnt = 0;
         end
         if (!bvalid && n_aw > n_b && n_w > n_b) begin
            if (b_cnt >= b_lat) begin
               bvalid = 1'b1;
               bresp  = (n_b == bad_beat) ? 2'b10 : 2'b00;
            end else begin
               b_cnt++;
            end
         end

         awv_p = awvalid; wv_p = wvalid; brdy_p = bready;
         awaddr_p = awaddr; wdata_p = wdata; wstrb_p = wstrb;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] a, input logic [31:0] d, input logic l, output bit ok);
      int n;
      n = 0;
      job_addr = a; job_data = d; job_last = l; job_valid = 1'b1;
      while (!job_ready && n < 200) begin tick(); n++; end
      ok = job_ready;
      tick();
      job_valid = 1'b0;
   endtask

   task automatic wait_b(input int target, output bit ok);
      int n;
      n = 0;
      while (n_b < target && n < 200) begin tick(); n++; end
      ok = (n_b >= target);
   endtask

   task automatic wait_done(input int base, output bit ok);
      int n;
      n = 0;
      while (done_cnt <= base && n < 200) begin tick(); n++; end
      ok = (done_cnt > base);
   endtask

   task automatic pulse_irq();
      irq_in = 1'b1;
      tick();
      irq_in = 1'b0;
   endtask

   task automatic test_reset();
      tick(); tick();
      checks++;
      if ({job_ready, awvalid, wvalid, bready, done_valid, done_err} !== 7'b0)
         $display("FAIL reset_outputs: got %b required 0000000",
                  {job_ready, awvalid, wvalid, bready, done_valid, done_err});
      else passed++;
      checks++;
      if (wstrb !== 4'hF) $display("FAIL reset_wstrb: got %h required f", wstrb);
      else passed++;
      rst_n = 1'b1;
      tick();
      checks++;
      if (job_ready !== 1'b1) $display("FAIL reset_ready_after_release: got %b required 1", job_ready);
      else passed++;
   endtask

   task automatic test_single_beat();
      bit ok_a, ok_b;
      int base_d, base_aw, base_b;
      aw_lat = 0; w_lat = 0; b_lat = 0;
      base_d = done_cnt; base_aw = aw_log.size(); base_b = n_b;
      send_beat(8'h04, 32'hDEADBEEF, 1'b1, ok_a);
      wait_b(base_b + 1, ok_b);
      checks++;
      if (!(ok_a && ok_b)) $display("FAIL single_handshakes: accept=%0b bresp=%0b required 1 1", ok_a, ok_b);
      else passed++;
      repeat (5) tick();
      pulse_irq();
      checks++;
      if ({done_valid, done_err} !== 3'b100)
         $display("FAIL single_done_after_irq: got valid=%b err=%b required valid=1 err=00", done_valid, done_err);
      else passed++;
      tick();
      checks++;
      if (done_valid !== 1'b0 || done_cnt != base_d + 1)
         $display("FAIL single_done_once: got valid=%b count=%0d required valid=0 count=%0d",
                  done_valid, done_cnt - base_d, 1);
      else passed++;
      checks++;
      if (aw_log.size() != base_aw + 1 || aw_log[aw_log.size()-1] !== 8'h04 ||
          w_log[w_log.size()-1] !== 32'hDEADBEEF || strb_bad != 0)
         $display("FAIL single_write: got %0d writes addr=%h data=%h strb_bad=%0d required 1 04 deadbeef 0",
                  aw_log.size() - base_aw, aw_log[aw_log.size()-1], w_log[w_log.size()-1], strb_bad);
      else passed++;
   endtask

   task automatic test_staggered_ready();
      bit ok0, ok1, ok2, okb, okd;
      int base_d, base_aw, base_b, base_only;
      logic [7:0]  exp_a [3];
      logic [31:0] exp_d [3];
      exp_a[0] = 8'h00; exp_a[1] = 8'h08; exp_a[2] = 8'h0C;
      exp_d[0] = 32'h11110000; exp_d[1] = 32'h22220008; exp_d[2] = 32'h3333000C;
      aw_lat = 2; w_lat = 0; b_lat = 0;
      base_d = done_cnt; base_aw = aw_log.size(); base_b = n_b; base_only = aw_only;
      send_beat(exp_a[0], exp_d[0], 1'b0, ok0);
      send_beat(exp_a[1], exp_d[1], 1'b0, ok1);
      send_beat(exp_a[2], exp_d[2], 1'b1, ok2);
      wait_b(base_b + 3, okb);
      pulse_irq();
      wait_done(base_d, okd);
      checks++;
      if (!(ok0 && ok1 && ok2 && okb && okd))
         $display("FAIL stagger_progress: got %0b%0b%0b%0b%0b required 11111", ok0, ok1, ok2, okb, okd);
      else passed++;
      checks++;
      if (aw_log.size() != base_aw + 3) $display("FAIL stagger_write_count: got %0d required 3", aw_log.size() - base_aw);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (aw_log[base_aw+i] !== exp_a[i] || w_log[base_aw+i] !== exp_d[i])
            $display("FAIL stagger_order_%0d: got %h/%h required %h/%h",
                     i, aw_log[base_aw+i], w_log[base_aw+i], exp_a[i], exp_d[i]);
         else passed++;
      end
      checks++;
      if (aw_only - base_only != 6)
         $display("FAIL stagger_awvalid_alone: got %0d cycles required 6", aw_only - base_only);
      else passed++;
      checks++;
      if (rdy_busy != 0) $display("FAIL stagger_ready_only_idle: got %0d busy-ready cycles required 0", rdy_busy);
      else passed++;
      checks++;
      if (done_err_last !== 2'b00) $display("FAIL stagger_done_err: got %b required 00", done_err_last);
      else passed++;
      aw_lat = 0;
   endtask

   task automatic test_bresp_error();
      bit ok0, ok1, ok2, okb, okd;
      int base_d, base_aw, base_b;
      base_d = done_cnt; base_aw = aw_log.size(); base_b = n_b;
      bad_beat = n_b + 1;
      send_beat(8'h10, 32'hA0A0A0A0, 1'b0, ok0);
      send_beat(8'h14, 32'hB1B1B1B1, 1'b0, ok1);
      send_beat(8'h18, 32'hC2C2C2C2, 1'b1, ok2);
      wait_b(base_b + 3, okb);
      pulse_irq();
      wait_done(base_d, okd);
      bad_beat = -1;
      checks++;
      if (!(ok0 && ok1 && ok2 && okb && okd))
         $display("FAIL berr_progress: got %0b%0b%0b%0b%0b required 11111", ok0, ok1, ok2, okb, okd);
      else passed++;
      checks++;
      if (aw_log.size() != base_aw + 3 || aw_log[base_aw+2] !== 8'h18)
         $display("FAIL berr_all_beats: got %0d writes required 3 ending at 18", aw_log.size() - base_aw);
      else passed++;
      checks++;
      if (done_err_last !== 2'b01) $display("FAIL berr_done_err: got %b required 01", done_err_last);
      else passed++;
   endtask

   task automatic test_timeout();
      bit oka, okd;
      int base_d;
      base_d = done_cnt;
      send_beat(8'h20, 32'h0000_0001, 1'b1, oka);
      wait_done(base_d, okd);
      checks++;
      if (!(oka && okd)) $display("FAIL timeout_progress: got %0b%0b required 11", oka, okd);
      else passed++;
      checks++;
      if (done_cyc - b_cyc != 17)
         $display("FAIL timeout_latency: got %0d cycles after WAIT_IRQ entry required 17", done_cyc - b_cyc);
      else passed++;
      checks++;
      if (done_err_last !== 2'b10) $display("FAIL timeout_done_err: got %b required 10", done_err_last);
      else passed++;
   endtask

   task automatic test_irq_before_b();
      bit oka, okd;
      int base_d, base_aw, n;
      base_d = done_cnt; base_aw = n_aw;
      b_lat = 4;
      send_beat(8'h24, 32'h5A5A5A5A, 1'b1, oka);
      n = 0;
      while (n_aw <= base_aw && n < 50) begin tick(); n++; end
      checks++;
      if (n_b != base_aw || bready !== 1'b1)
         $display("FAIL early_irq_setup: got bready=%b b_outstanding=%0d required 1 1", bready, n_aw - n_b);
      else passed++;
      pulse_irq();
      wait_done(base_d, okd);
      b_lat = 0;
      checks++;
      if (!(oka && okd)) $display("FAIL early_irq_progress: got %0b%0b required 11", oka, okd);
      else passed++;
      checks++;
      if (done_cyc - b_cyc != 1)
         $display("FAIL early_irq_latency: got %0d cycles after WAIT_IRQ entry required 1", done_cyc - b_cyc);
      else passed++;
      checks++;
      if (done_err_last !== 2'b00) $display("FAIL early_irq_done_err: got %b required 00", done_err_last);
      else passed++;
   endtask

   task automatic test_reset_mid_job();
      bit oka, okb, okd;
      int base_d, base_b;
      aw_lat = 5; w_lat = 5;
      base_d = done_cnt;
      send_beat(8'h30, 32'h0BAD0BAD, 1'b1, oka);
      checks++;
      if (!oka || awvalid !== 1'b1) $display("FAIL rstmid_setup: got accept=%0b awvalid=%b required 1 1", oka, awvalid);
      else passed++;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({awvalid, wvalid, bready, done_valid, job_ready} !== 5'b0)
         $display("FAIL rstmid_outputs: got %b required 00000", {awvalid, wvalid, bready, done_valid, job_ready});
      else passed++;
      tick(); tick();
      aw_lat = 0; w_lat = 0;
      rst_n = 1'b1;
      tick();
      checks++;
      if (job_ready !== 1'b1) $display("FAIL rstmid_ready_after: got %b required 1", job_ready);
      else passed++;
      base_b = n_b;
      send_beat(8'h34, 32'hCAFEF00D, 1'b1, oka);
      wait_b(base_b + 1, okb);
      pulse_irq();
      wait_done(base_d, okd);
      checks++;
      if (!(oka && okb && okd) || done_cnt != base_d + 1 || done_err_last !== 2'b00)
         $display("FAIL rstmid_next_job: got progress=%0b%0b%0b dones=%0d err=%b required 111 1 00",
                  oka, okb, okd, done_cnt - base_d, done_err_last);
      else passed++;
      checks++;
      if (aw_log[aw_log.size()-1] !== 8'h34 || w_log[w_log.size()-1] !== 32'hCAFEF00D)
         $display("FAIL rstmid_next_write: got %h/%h required 34/cafef00d",
                  aw_log[aw_log.size()-1], w_log[w_log.size()-1]);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_staggered_ready();
      test_bresp_error();
      test_timeout();
      test_irq_before_b();
      test_reset_mid_job();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
